// File: rtl/mux_share_arbiter_if.sv
// Handshake bundle between two requesters and the shared-mux arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold req until they see their grant; no other throttling.
//   ARB_LOCK_EN adds lock_a/lock_b owner tenure-lock inputs.
interface mux_share_arbiter_if #(parameter int W = 4);
  logic         req_a;
  logic         req_b;
  logic [W-1:0] data_a;
  logic [W-1:0] data_b;
  logic         grant_a;
  logic         grant_b;
  logic         sel;
  logic [W-1:0] data_out;
  logic         valid;
`ifdef ARB_LOCK_EN
  logic         lock_a;
  logic         lock_b;

  modport master (
    output req_a, req_b, data_a, data_b, lock_a, lock_b,
    input  grant_a, grant_b, sel, data_out, valid
  );

  modport slave (
    input  req_a, req_b, data_a, data_b, lock_a, lock_b,
    output grant_a, grant_b, sel, data_out, valid
  );
`else
  modport master (
    output req_a, req_b, data_a, data_b,
    input  grant_a, grant_b, sel, data_out, valid
  );

  modport slave (
    input  req_a, req_b, data_a, data_b,
    output grant_a, grant_b, sel, data_out, valid
  );
`endif
endinterface

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter owning one W-bit 2:1 mux between requesters A and B; registers the selected word.
// Latency: 1 cycle from req sample to grant/sel/valid/data_out; handover A<->B has no idle bubble.
// Backpressure: loser waits on req; owner capped at MAX_HOLD cycles while the other waits (ARB_LOCK_EN: owner lock lifts cap).
module mux_share_arbiter #(
  parameter int W        = 4,
  parameter int MAX_HOLD = 8
) (
  input logic                clk,
  input logic                rst,
  mux_share_arbiter_if.slave bus
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux_share_arbiter: MAX_HOLD must be in 1..255");
  end

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t       state;
  state_t       state_nxt;
  logic [7:0]   hold_cnt;
  logic         last_b;     // side granted most recently; 1 = B, so A wins the first tie
  logic         tenure_up;
  logic         lock_a;
  logic         lock_b;
  logic [W-1:0] data_nxt;

`ifdef ARB_LOCK_EN
  assign lock_a = bus.lock_a;
  assign lock_b = bus.lock_b;
`else
  assign lock_a = 1'b0;
  assign lock_b = 1'b0;
`endif

  assign tenure_up = (hold_cnt == HOLD_LAST);

  // Next owner: tie-break on last winner from IDLE, immediate handover on req drop,
  // preemption once the owner has used its full tenure while the other side waits.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_a && bus.req_b) state_nxt = last_b ? GRANT_A : GRANT_B;
        else if (bus.req_a)         state_nxt = GRANT_A;
        else if (bus.req_b)         state_nxt = GRANT_B;
      end
      GRANT_A: begin
        if (!bus.req_a)                          state_nxt = bus.req_b ? GRANT_B : IDLE;
        else if (bus.req_b && tenure_up && !lock_a) state_nxt = GRANT_B;
      end
      GRANT_B: begin
        if (!bus.req_b)                          state_nxt = bus.req_a ? GRANT_A : IDLE;
        else if (bus.req_a && tenure_up && !lock_b) state_nxt = GRANT_A;
      end
      default: state_nxt = IDLE;
    endcase
    data_nxt = (state_nxt == GRANT_B) ? bus.data_b : bus.data_a;
  end

  // Register state, tenure counter, round-robin pointer and all outputs together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= 8'd0;
      last_b       <= 1'b1;
      bus.grant_a  <= 1'b0;
      bus.grant_b  <= 1'b0;
      bus.valid    <= 1'b0;
      bus.sel      <= 1'b0;
      bus.data_out <= '0;
    end else begin
      state       <= state_nxt;
      bus.grant_a <= (state_nxt == GRANT_A);
      bus.grant_b <= (state_nxt == GRANT_B);
      bus.valid   <= (state_nxt != IDLE);

      if (state_nxt != state)
        hold_cnt <= 8'd0;
      else if (state_nxt != IDLE && !tenure_up)
        hold_cnt <= hold_cnt + 8'd1;

      if (state_nxt != state && state_nxt != IDLE)
        last_b <= (state_nxt == GRANT_B);

      // sel/data_out only move while someone owns the mux; IDLE keeps the last word visible
      if (state_nxt != IDLE) begin
        bus.sel      <= (state_nxt == GRANT_B);
        bus.data_out <= data_nxt;
      end
    end
  end

endmodule
